// File: rtl/recovery_cmd_engine.sv
// Recovery-protocol command engine: decodes a host command, moves write payload from the
// TTI RX queue into the CSR window, or streams CSR bytes out as a read response.
module recovery_cmd_engine #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned NumCsrWords = 32,
    parameter int unsigned LenWidth    = 16,
    localparam int unsigned AW         = $clog2(NumCsrWords)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    input  logic                 cmd_is_rd_i,
    input  logic [7:0]           cmd_cmd_i,
    input  logic [LenWidth-1:0]  cmd_len_i,
    input  logic                 cmd_error_i,
    output logic                 cmd_done_o,
    output logic [7:0]           desc_cmd_o,
    input  logic                 desc_valid_i,
    input  logic [AW-1:0]        desc_base_i,
    input  logic [LenWidth-1:0]  desc_len_i,
    input  logic                 desc_wr_i,
    output logic [AW-1:0]        csr_addr_o,
    input  logic [DataWidth-1:0] csr_rdata_i,
    output logic                 csr_we_o,
    output logic [DataWidth-1:0] csr_wdata_o,
    output logic                 rx_req_o,
    input  logic                 rx_ack_i,
    input  logic [DataWidth-1:0] rx_data_i,
    output logic                 rx_queue_clr_o,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [LenWidth-1:0]  res_len_o,
    output logic                 res_dvalid_o,
    input  logic                 res_dready_i,
    output logic [7:0]           res_data_o,
    output logic                 res_dlast_o,
    input  logic                 tx_host_nack_i,
    output logic                 status_we_o,
    output logic [7:0]           status_protocol_o
);

    localparam int unsigned Bpw  = DataWidth / 8;
    localparam int unsigned BW   = (Bpw > 1) ? $clog2(Bpw) : 1;
    localparam int unsigned SumW = ((AW > LenWidth + 1) ? AW : LenWidth + 1) + 1;

    typedef enum logic [2:0] {
        StIdle, StDecode, StWrite, StReadHdr, StReadData, StError, StDone
    } state_e;

    state_e              state_q, state_d;
    logic                is_rd_q, is_rd_d;
    logic                crc_q, crc_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [7:0]          code_q, code_d;
    logic [LenWidth-1:0] len_q, len_d;
    logic [LenWidth-1:0] dlen_q, dlen_d;
    logic [LenWidth-1:0] bcnt_q, bcnt_d;
    logic [AW-1:0]       base_q, base_d;
    logic [LenWidth:0]   widx_q, widx_d;
    logic [BW-1:0]       bidx_q, bidx_d;

    logic [LenWidth:0]    words;
    logic [SumW-1:0]      addr_sum;
    logic                 in_win;
    logic [AW-1:0]        addr_sat;
    logic                 last_byte;
    logic [DataWidth-1:0] rdata_sh;
    logic [7:0]           err_code;

    // Word count is one bit wider than the length so the round-up cannot wrap.
    assign words     = ({1'b0, len_q} + (LenWidth+1)'(Bpw - 1)) / (LenWidth+1)'(Bpw);
    assign addr_sum  = SumW'(base_q) + SumW'(widx_q);
    assign in_win    = addr_sum < SumW'(NumCsrWords);
    assign addr_sat  = in_win ? addr_sum[AW-1:0] : AW'(NumCsrWords - 1);
    assign last_byte = ({1'b0, bcnt_q} + 1'b1) == {1'b0, dlen_q};
    assign rdata_sh  = csr_rdata_i >> {bidx_q, 3'b000};
    assign desc_cmd_o = cmd_q;

    always_comb begin
        err_code = 8'h00;
        if (crc_q) begin
            err_code = 8'h04;
        end else if (!desc_valid_i) begin
            err_code = 8'h02;
        end else if (!is_rd_q && !desc_wr_i) begin
            err_code = 8'h01;
        end else if (!is_rd_q && (len_q != desc_len_i)) begin
            err_code = 8'h03;
        end
    end

    always_comb begin
        state_d = state_q;
        is_rd_d = is_rd_q;
        crc_d   = crc_q;
        cmd_d   = cmd_q;
        code_d  = code_q;
        len_d   = len_q;
        dlen_d  = dlen_q;
        bcnt_d  = bcnt_q;
        base_d  = base_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;

        cmd_done_o        = 1'b0;
        csr_addr_o        = '0;
        csr_we_o          = 1'b0;
        csr_wdata_o       = '0;
        rx_req_o          = 1'b0;
        rx_queue_clr_o    = 1'b0;
        res_valid_o       = 1'b0;
        res_len_o         = '0;
        res_dvalid_o      = 1'b0;
        res_data_o        = 8'h00;
        res_dlast_o       = 1'b0;
        status_we_o       = 1'b0;
        status_protocol_o = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    is_rd_d = cmd_is_rd_i;
                    cmd_d   = cmd_cmd_i;
                    len_d   = cmd_len_i;
                    crc_d   = cmd_error_i;
                    code_d  = 8'h00;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (err_code != 8'h00) begin
                    code_d  = err_code;
                    state_d = StError;
                end else begin
                    base_d  = desc_base_i;
                    dlen_d  = desc_len_i;
                    widx_d  = '0;
                    bidx_d  = '0;
                    bcnt_d  = '0;
                    state_d = is_rd_q ? StReadHdr : StWrite;
                end
            end
            StWrite: begin
                csr_addr_o = addr_sat;
                if (widx_q < words) begin
                    rx_req_o = 1'b1;
                    if (rx_ack_i) begin
                        // Words past the end of the window are consumed but not written.
                        csr_we_o    = in_win;
                        csr_wdata_o = in_win ? rx_data_i : '0;
                        widx_d      = widx_q + 1'b1;
                        if ((widx_q + 1'b1) == words) state_d = StDone;
                    end
                end else begin
                    state_d = StDone;
                end
            end
            StReadHdr: begin
                res_valid_o = 1'b1;
                res_len_o   = dlen_q;
                if (res_ready_i) state_d = (dlen_q == '0) ? StDone : StReadData;
            end
            StReadData: begin
                csr_addr_o   = addr_sat;
                res_dvalid_o = 1'b1;
                res_data_o   = rdata_sh[7:0];
                res_dlast_o  = last_byte;
                if (tx_host_nack_i) begin
                    state_d = StDone;
                end else if (res_dready_i) begin
                    if (last_byte) begin
                        state_d = StDone;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                        if (bidx_q == BW'(Bpw - 1)) begin
                            bidx_d = '0;
                            widx_d = widx_q + 1'b1;
                        end else begin
                            bidx_d = bidx_q + 1'b1;
                        end
                    end
                end
            end
            StError: begin
                rx_queue_clr_o = 1'b1;
                state_d        = StDone;
            end
            StDone: begin
                cmd_done_o        = 1'b1;
                status_we_o       = 1'b1;
                status_protocol_o = code_q;
                state_d           = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            is_rd_q <= 1'b0;
            crc_q   <= 1'b0;
            cmd_q   <= 8'h00;
            code_q  <= 8'h00;
            len_q   <= '0;
            dlen_q  <= '0;
            bcnt_q  <= '0;
            base_q  <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
        end else begin
            state_q <= state_d;
            is_rd_q <= is_rd_d;
            crc_q   <= crc_d;
            cmd_q   <= cmd_d;
            code_q  <= code_d;
            len_q   <= len_d;
            dlen_q  <= dlen_d;
            bcnt_q  <= bcnt_d;
            base_q  <= base_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
        end
    end

endmodule

// File: tb/tb_recovery_cmd_engine.sv
// Scoreboard bench for recovery_cmd_engine: 32-bit and 64-bit instances, directed commands,
// expected events queued by the stimulus and checked by a negedge monitor.
module tb_recovery_cmd_engine;

    localparam int KWe = 0, KClr = 1, KHdr = 2, KByte = 3, KDone = 4, KWe64 = 5, KDone64 = 6;

    typedef struct {
        int          kind;
        logic [63:0] val;
        int          addr;
    } ev_t;

    typedef struct packed {
        logic        v;
        logic [4:0]  b;
        logic [15:0] l;
        logic        w;
    } desc_t;

    function automatic desc_t dec(input logic [7:0] c);
        case (c)
            8'h26:   return '{v: 1'b1, b: 5'd14, l: 16'd3,  w: 1'b1};
            8'h22:   return '{v: 1'b1, b: 5'd0,  l: 16'd15, w: 1'b0};
            8'h40:   return '{v: 1'b1, b: 5'd2,  l: 16'd24, w: 1'b0};
            8'h50:   return '{v: 1'b1, b: 5'd20, l: 16'd8,  w: 1'b1};
            8'h51:   return '{v: 1'b1, b: 5'd4,  l: 16'd6,  w: 1'b1};
            8'h52:   return '{v: 1'b1, b: 5'd30, l: 16'd12, w: 1'b1};
            default: return '{v: 1'b0, b: 5'd0,  l: 16'd0,  w: 1'b0};
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared command inputs; each instance has its own valid, reset and RX handshake.
    logic        rst_n = 1'b0, rst64_n = 1'b0;
    logic        cmd_valid = 1'b0, v64 = 1'b0;
    logic        cmd_is_rd = 1'b0, cmd_error = 1'b0;
    logic [7:0]  cmd_cmd = 8'h00;
    logic [15:0] cmd_len = 16'd0;
    logic        rx_ack = 1'b0, ack64 = 1'b0;
    logic [31:0] rx_data = 32'h0;
    logic [63:0] data64 = 64'h0;
    logic        res_ready = 1'b0, res_dready = 1'b0, nack = 1'b0;

    logic        cmd_done, csr_we, rx_req, rx_clr, res_valid, res_dvalid, res_dlast, status_we;
    logic [7:0]  desc_cmd, res_data, status;
    logic [4:0]  csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic [15:0] res_len;
    desc_t       d32;

    logic        done64, we64, req64, clr64, rv64, dv64, dlast64, sw64;
    logic [7:0]  dcmd64, rd64, st64;
    logic [4:0]  addr64;
    logic [63:0] wdata64;
    logic [15:0] rl64;
    desc_t       d64;

    assign d32 = dec(desc_cmd);
    assign d64 = dec(dcmd64);

    // CSR word a holds bytes 4a..4a+3, least-significant first.
    logic [7:0] a8;
    always_comb begin
        a8        = {1'b0, csr_addr, 2'b00};
        csr_rdata = {a8 + 8'd3, a8 + 8'd2, a8 + 8'd1, a8};
    end

    recovery_cmd_engine #(.DataWidth(32)) dut32 (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_is_rd_i(cmd_is_rd), .cmd_cmd_i(cmd_cmd),
        .cmd_len_i(cmd_len), .cmd_error_i(cmd_error), .cmd_done_o(cmd_done),
        .desc_cmd_o(desc_cmd), .desc_valid_i(d32.v), .desc_base_i(d32.b),
        .desc_len_i(d32.l), .desc_wr_i(d32.w),
        .csr_addr_o(csr_addr), .csr_rdata_i(csr_rdata), .csr_we_o(csr_we),
        .csr_wdata_o(csr_wdata), .rx_req_o(rx_req), .rx_ack_i(rx_ack), .rx_data_i(rx_data),
        .rx_queue_clr_o(rx_clr), .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_len_o(res_len), .res_dvalid_o(res_dvalid), .res_dready_i(res_dready),
        .res_data_o(res_data), .res_dlast_o(res_dlast), .tx_host_nack_i(nack),
        .status_we_o(status_we), .status_protocol_o(status)
    );

    recovery_cmd_engine #(.DataWidth(64)) dut64 (
        .clk_i(clk), .rst_ni(rst64_n),
        .cmd_valid_i(v64), .cmd_is_rd_i(cmd_is_rd), .cmd_cmd_i(cmd_cmd),
        .cmd_len_i(cmd_len), .cmd_error_i(cmd_error), .cmd_done_o(done64),
        .desc_cmd_o(dcmd64), .desc_valid_i(d64.v), .desc_base_i(d64.b),
        .desc_len_i(d64.l), .desc_wr_i(d64.w),
        .csr_addr_o(addr64), .csr_rdata_i(64'h0), .csr_we_o(we64),
        .csr_wdata_o(wdata64), .rx_req_o(req64), .rx_ack_i(ack64), .rx_data_i(data64),
        .rx_queue_clr_o(clr64), .res_valid_o(rv64), .res_ready_i(1'b0),
        .res_len_o(rl64), .res_dvalid_o(dv64), .res_dready_i(1'b0),
        .res_data_o(rd64), .res_dlast_o(dlast64), .tx_host_nack_i(1'b0),
        .status_we_o(sw64), .status_protocol_o(st64)
    );

    ev_t q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic expect_ev(input int k, input logic [63:0] v, input int a);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.addr = a;
        q.push_back(e);
    endtask

    task automatic got(input int k, input logic [63:0] v, input int a);
        ev_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected event: got kind=%0d val=%0h addr=%0d, required none",
                     k, v, a);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.val !== v || e.addr != a) begin
                n_bad++;
                $display("FAIL event: got kind=%0d val=%0h addr=%0d, required kind=%0d val=%0h addr=%0d",
                         k, v, a, e.kind, e.val, e.addr);
            end
        end
    endtask

    // Handshakes coincident with a host NACK are discarded by the DUT, so not recorded.
    always @(negedge clk) begin
        if (csr_we) got(KWe, 64'(csr_wdata), int'(csr_addr));
        if (rx_clr) got(KClr, 64'h0, 0);
        if (res_valid && res_ready) got(KHdr, 64'(res_len), 0);
        if (res_dvalid && res_dready && !nack) got(KByte, {55'h0, res_dlast, res_data}, 0);
        if (cmd_done) got(KDone, 64'(status), int'(status_we));
        if (we64) got(KWe64, wdata64, int'(addr64));
        if (done64) got(KDone64, 64'(st64), int'(sw64));
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input bit d64, input logic [7:0] c, input logic rd,
                         input logic [15:0] l, input logic e);
        cmd_cmd   = c;
        cmd_is_rd = rd;
        cmd_len   = l;
        cmd_error = e;
        if (d64) v64 = 1'b1;
        else cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        v64       = 1'b0;
        cmd_error = 1'b0;
    endtask

    task automatic wait_req(input bit d64, input string nm);
        for (int i = 0; i < 20 && !(d64 ? req64 : rx_req); i++) step();
        check(nm, 128'(d64 ? req64 : rx_req), 128'd1);
    endtask

    function automatic logic [127:0] outs32();
        return 128'({cmd_done, desc_cmd, csr_addr, csr_we, csr_wdata, rx_req, rx_clr, res_valid,
                     res_len, res_dvalid, res_data, res_dlast, status_we, status});
    endfunction

    function automatic logic [127:0] outs64();
        return 128'({done64, dcmd64, addr64, we64, wdata64, req64, clr64, rv64,
                     rl64, dv64, rd64, dlast64, sw64, st64});
    endfunction

    initial begin
        #2;
        check("reset_outs32", outs32(), 128'd0);
        check("reset_outs64", outs64(), 128'd0);
        step(2);
        rst_n   = 1'b1;
        rst64_n = 1'b1;
        step(2);

        // Single-word write; the second ack arrives with rx_req_o low and must be ignored.
        expect_ev(KWe, 64'h00AA5501, 14);
        expect_ev(KDone, 64'h00, 1);
        issue(0, 8'd38, 1'b0, 16'd3, 1'b0);
        wait_req(0, "wr38_req");
        rx_ack  = 1'b1;
        rx_data = 32'h00AA5501;
        step(2);
        rx_ack  = 1'b0;
        rx_data = 32'h0;
        step(3);

        // Read with delayed header accept and toggling byte ready; length field ignored.
        expect_ev(KHdr, 64'd15, 0);
        for (int k = 0; k < 15; k++) expect_ev(KByte, {55'h0, (k == 14), 8'(k)}, 0);
        expect_ev(KDone, 64'h00, 1);
        issue(0, 8'd34, 1'b1, 16'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            res_ready  = (i >= 2);
            res_dready = (i % 2 == 1);
            step();
        end
        res_ready  = 1'b0;
        res_dready = 1'b0;
        step(2);

        expect_ev(KClr, 64'h0, 0);
        expect_ev(KDone, 64'h04, 1);
        issue(0, 8'd34, 1'b0, 16'd15, 1'b1);
        step(5);

        expect_ev(KClr, 64'h0, 0);
        expect_ev(KDone, 64'h01, 1);
        issue(0, 8'd34, 1'b0, 16'd15, 1'b0);
        step(5);

        expect_ev(KClr, 64'h0, 0);
        expect_ev(KDone, 64'h03, 1);
        issue(0, 8'd38, 1'b0, 16'd4, 1'b0);
        step(5);

        expect_ev(KClr, 64'h0, 0);
        expect_ev(KDone, 64'h02, 1);
        issue(0, 8'h99, 1'b0, 16'd3, 1'b0);
        step(5);

        // 24-byte read from word 2; NACK lands on the sixth byte together with a handshake.
        expect_ev(KHdr, 64'd24, 0);
        for (int k = 0; k < 5; k++) expect_ev(KByte, {56'h0, 8'(8 + k)}, 0);
        expect_ev(KDone, 64'h00, 1);
        res_ready  = 1'b1;
        res_dready = 1'b1;
        issue(0, 8'h40, 1'b1, 16'd0, 1'b0);
        for (int i = 0; i < 30 && !(res_dvalid && res_data == 8'd13); i++) step();
        check("nack_byte5_seen", 128'(res_dvalid && res_data == 8'd13), 128'd1);
        nack = 1'b1;
        step();
        nack = 1'b0;
        step(6);
        res_ready  = 1'b0;
        res_dready = 1'b0;

        // Three words from base 30: the third falls outside the window and is dropped.
        expect_ev(KWe, 64'hA0A0A0A0, 30);
        expect_ev(KWe, 64'hB1B1B1B1, 31);
        expect_ev(KDone, 64'h00, 1);
        issue(0, 8'h52, 1'b0, 16'd12, 1'b0);
        wait_req(0, "sat_req");
        rx_ack  = 1'b1;
        rx_data = 32'hA0A0A0A0;
        step();
        rx_data = 32'hB1B1B1B1;
        step();
        rx_data = 32'hC2C2C2C2;
        step();
        rx_ack  = 1'b0;
        step(4);

        // Reset mid-write after the first of two words: no further strobe or completion.
        expect_ev(KWe, 64'h11112222, 20);
        issue(0, 8'h50, 1'b0, 16'd8, 1'b0);
        wait_req(0, "rst_req");
        rx_ack  = 1'b1;
        rx_data = 32'h11112222;
        step();
        rx_ack  = 1'b0;
        check("rst_pre_req", 128'(rx_req), 128'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs32", outs32(), 128'd0);
        step(2);
        rst_n = 1'b1;
        step(4);
        check("rst_after_outs32", outs32(), 128'd0);

        // 64-bit instance: a 6-byte write is one word; extra acks must not strobe again.
        expect_ev(KWe64, 64'h0123456789ABCDEF, 4);
        expect_ev(KDone64, 64'h00, 1);
        issue(1, 8'h51, 1'b0, 16'd6, 1'b0);
        wait_req(1, "wr64_req");
        ack64  = 1'b1;
        data64 = 64'h0123456789ABCDEF;
        step(3);
        ack64  = 1'b0;
        step(4);

        issue(1, 8'h51, 1'b0, 16'd6, 1'b0);
        wait_req(1, "rst64_req");
        rst64_n = 1'b0;
        #1;
        check("rst_mid_outs64", outs64(), 128'd0);
        step(2);
        rst64_n = 1'b1;
        step(4);

        check("queue_drained", 128'(q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
